sensor_rsp_checker: RTL
=======================

// Module: sensor_rsp_checker
// PURPOSE
//  Parses SDM sensor-read response packets (Avalon-ST, 32b) for any voltage or temperature channel.
//  Compares each sample against per-channel min/max thresholds, programmable at runtime.
//  Debounces out-of-range results and drives per-channel OK flags plus aggregate good/fault to the safety logic.
//  Successor to the fixed-limit response checker: any channel count, runtime limits, signed/unsigned, debounce.
// PARAMETERS
//  P_NO_CH     16  number of monitored channels (1..64)
//  P_CH_W      $clog2(P_NO_CH)  channel index width (derived, do not override)
//  P_DEBOUNCE  3   consecutive out-of-range samples before channel fault (1..15)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  req_strobe_i   in   1          request issued; latch req_ch_i as channel of next response
//  req_ch_i       in   P_CH_W     channel index of issued request
//  rsp_ready_o    out  1          response ready
//  rsp_valid_i    in   1          response word valid
//  rsp_data_i     in   32         response word
//  rsp_sop_i      in   1          start of packet (header word)
//  rsp_eop_i      in   1          end of packet
//  cfg_wr_i       in   1          threshold/config write strobe
//  cfg_addr_i     in   P_CH_W+2   {channel, sel}; sel 0=min, 1=max, 2=ctrl{bit1 signed, bit0 enable}
//  cfg_wdata_i    in   32         write data
//  fault_clr_i    in   1          clear latched fault (sticky build only)
//  sample_o       out  P_NO_CH*32 last accepted sample per channel
//  ch_ok_o        out  P_NO_CH    per-channel OK flag
//  all_good_o     out  1          AND of ch_ok_o
//  fault_o        out  1          fault indication
//  sample_done_o  out  1          1-cycle pulse: sample stored
//  proto_err_o    out  1          1-cycle pulse: protocol/SDM error
// BEHAVIOUR
//  Reset: FSM=IDLE; rsp_ready_o=0 while reset, 1 otherwise.
//   sample_o=0; ch_ok_o='1; all_good_o=1; fault_o=0; pulses=0; min=0, max=32'hFFFF_FFFF, ctrl=0 (disabled).
//  FSM states IDLE, HDR_CHK, DATA, DROP. Transitions advance only on accepted beats (valid&ready).
//   IDLE: beat with sop -> check header; err=data[10:0]!=0 -> DROP (proto_err pulse), else DATA.
//     sop&eop on the header beat -> proto_err pulse, stay IDLE.
//     Beat without sop -> discard, proto_err pulse.
//   DATA: store each beat; eop beat = sample -> write sample_o[ch], sample_done pulse, -> IDLE.
//   DROP: discard until eop -> IDLE.
//   sop in DATA/DROP -> proto_err pulse; restart header check on that beat.
//  ch = value latched on last req_strobe_i; strobe while busy updates latch for the next packet only.
//  Latency from eop beat at cycle N: sample_o/sample_done N+1; ch_ok_o N+2; all_good_o/fault_o N+3.
//  Compare: in range iff min<=sample<=max; signed two's-complement if ctrl.signed, else unsigned.
//  Debounce per channel (4b, saturating): out-of-range -> cnt+1; cnt reaching P_DEBOUNCE -> ch_ok=0.
//   In-range sample -> cnt=0, ch_ok=1. Only the addressed channel is evaluated.
//  Disabled channel: ch_ok=1, cnt=0; samples are still stored.
//  cfg write and sample in the same cycle on the same channel: compare uses the pre-write thresholds.
//  A write to ctrl clears that channel's cnt.
//  Reset mid-packet: FSM->IDLE; remaining beats without sop are discarded with proto_err.
// CONFIGURATION
//  SENSOR_RSP_STICKY_EN defined: fault_o sets on any ch_ok=0 and holds until fault_clr_i.
//   While any channel is still bad, fault_clr_i has no effect.
//  Not defined: fault_o = ~all_good_o (registered); fault_clr_i ignored.
// STRUCTURE
//  Package sensor_rsp_pkg: t_rsp_state enum, t_thresh struct {min,max,en,signed}, CFG_SEL_* constants,
//   SDM_ERR_MSB=10.
//  Sub-module sensor_rsp_ch_eval: one channel's compare, debounce counter and ch_ok flag.
//   Instantiated P_NO_CH times by generate; the top holds the FSM, cfg decode and aggregation.
// TESTING
//  1 ch3 min=0xA767 max=0xF4DB en; response 0x0000_0000 hdr + 0xC000 eop -> sample_o[3]=0xC000, ch_ok[3]=1 at N+2.
//  2 ch3 sample 0x1_0000 x3 -> ch_ok[3] drops after 3rd sample; all_good=0 at N+3; one in-range -> recovers.
//  3 hdr 0x0000_0005 (err) + 2 data beats -> proto_err 1 pulse, no sample_done, sample_o unchanged.
//  4 ch1 signed, min=-10<<8, max=80<<8; sample 0xFFFF_F600 -> in range; unsigned mode -> out of range.
//  5 sop mid-DATA -> proto_err pulse, new packet stored correctly; data beat with no sop in IDLE -> proto_err.
//  6 STICKY build: fault after debounce, in-range sample -> fault_o stays 1 until fault_clr_i; non-sticky build clears.

Source files
------------

// File: rtl/sensor_rsp_pkg.sv
// Shared types for the SDM sensor response checker: FSM encoding, per-channel
// threshold record and configuration select codes.
package sensor_rsp_pkg;

    localparam int RSP_W       = 32;
    localparam int SDM_ERR_MSB = 10;

    localparam logic [1:0] CFG_SEL_MIN  = 2'd0;
    localparam logic [1:0] CFG_SEL_MAX  = 2'd1;
    localparam logic [1:0] CFG_SEL_CTRL = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        HDR_CHK,
        DATA,
        DROP
    } t_rsp_state;

    typedef struct packed {
        logic [RSP_W-1:0] min;
        logic [RSP_W-1:0] max;
        logic             en;
        logic             sgn;
    } t_thresh;

    localparam t_thresh THRESH_RST = '{min: '0, max: '1, en: 1'b0, sgn: 1'b0};

endpackage

// File: rtl/sensor_rsp_ch_eval.sv
// One monitored channel: range compare of the incoming eop word, saturating
// debounce counter and the channel OK flag.
module sensor_rsp_ch_eval
    import sensor_rsp_pkg::*;
#(
    parameter int P_DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  t_thresh          thresh_i,
    input  logic [RSP_W-1:0] sample_i,
    input  logic             eval_i,
    input  logic             ctrl_wr_i,
    output logic             ch_ok_o
);

    logic       in_range;
    logic       in_range_p0;
    logic       vld_p0;
    logic [3:0] cnt_q;
    logic [3:0] cnt_inc;
    logic       ok_q;

    // Compare runs in the eop cycle, so a threshold write in that same cycle is not yet visible.
    always_comb begin
        if (thresh_i.sgn) begin
            in_range = ($signed(thresh_i.min) <= $signed(sample_i)) &&
                       ($signed(sample_i) <= $signed(thresh_i.max));
        end else begin
            in_range = (thresh_i.min <= sample_i) && (sample_i <= thresh_i.max);
        end
    end

    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // p0: registered compare result of the eop word
    always_ff @(posedge clk) begin
        in_range_p0 <= in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= eval_i;
        end
    end

    // p1: debounce update
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ok_q  <= 1'b1;
        end else if (!thresh_i.en) begin
            cnt_q <= '0;
            ok_q  <= 1'b1;
        end else if (ctrl_wr_i) begin
            cnt_q <= '0;
        end else if (vld_p0) begin
            if (in_range_p0) begin
                cnt_q <= '0;
                ok_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_inc;
                if (cnt_inc >= 4'(P_DEBOUNCE)) begin
                    ok_q <= 1'b0;
                end
            end
        end
    end

    assign ch_ok_o = ok_q;

endmodule

// File: rtl/sensor_rsp_checker.sv
// SDM sensor-read response checker: packet FSM, threshold registers, per-channel evaluators, aggregation.
// Build option SENSOR_RSP_STICKY_EN: fault_o latches on any bad channel until fault_clr_i.
module sensor_rsp_checker
    import sensor_rsp_pkg::*;
#(
    parameter int P_NO_CH    = 16,
    parameter int P_CH_W     = (P_NO_CH > 1) ? $clog2(P_NO_CH) : 1,
    parameter int P_DEBOUNCE = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_strobe_i,
    input  logic [P_CH_W-1:0]        req_ch_i,
    output logic                     rsp_ready_o,
    input  logic                     rsp_valid_i,
    input  logic [RSP_W-1:0]         rsp_data_i,
    input  logic                     rsp_sop_i,
    input  logic                     rsp_eop_i,
    input  logic                     cfg_wr_i,
    input  logic [P_CH_W+1:0]        cfg_addr_i,
    input  logic [RSP_W-1:0]         cfg_wdata_i,
    input  logic                     fault_clr_i,
    output logic [P_NO_CH*RSP_W-1:0] sample_o,
    output logic [P_NO_CH-1:0]       ch_ok_o,
    output logic                     all_good_o,
    output logic                     fault_o,
    output logic                     sample_done_o,
    output logic                     proto_err_o
);

    t_rsp_state               state_q, state_d;
    logic [P_CH_W-1:0]        req_ch_q, pkt_ch_q;
    t_thresh                  thresh_q [P_NO_CH];
    logic [P_NO_CH*RSP_W-1:0] sample_q;
    logic [P_NO_CH-1:0]       ch_ok, ctrl_wr, eval;
    logic                     beat, hdr_err, sample_hit, proto_err_d;
    logic                     sample_done_q, proto_err_q, all_good_q, fault_q;
    logic [P_CH_W-1:0]        cfg_ch;
    logic [1:0]               cfg_sel;

    assign rsp_ready_o = ~reset;
    assign beat        = rsp_valid_i & rsp_ready_o;
    assign hdr_err     = |rsp_data_i[SDM_ERR_MSB:0];
    assign cfg_ch      = cfg_addr_i[P_CH_W+1:2];
    assign cfg_sel     = cfg_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any sop beat restarts header checking regardless of the current state.
    always_comb begin
        state_d = state_q;
        if (beat) begin
            if (rsp_sop_i) begin
                if (rsp_eop_i)    state_d = IDLE;
                else if (hdr_err) state_d = DROP;
                else              state_d = HDR_CHK;
            end else begin
                case (state_q)
                    HDR_CHK, DATA: state_d = rsp_eop_i ? IDLE : DATA;
                    DROP:          state_d = rsp_eop_i ? IDLE : DROP;
                    default:       state_d = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        proto_err_d = 1'b0;
        sample_hit  = 1'b0;
        if (beat) begin
            if (rsp_sop_i) begin
                proto_err_d = rsp_eop_i | hdr_err | (state_q != IDLE);
            end else begin
                proto_err_d = (state_q == IDLE);
                sample_hit  = rsp_eop_i & ((state_q == HDR_CHK) | (state_q == DATA));
            end
        end
    end

    // The packet channel is frozen at the header beat; later strobes only re-arm the latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ch_q <= '0;
            pkt_ch_q <= '0;
        end else begin
            if (req_strobe_i)      req_ch_q <= req_ch_i;
            if (beat && rsp_sop_i) pkt_ch_q <= req_ch_q;
        end
    end

    // p0: sample store and event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q      <= '0;
            sample_done_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            sample_done_q <= sample_hit;
            proto_err_q   <= proto_err_d;
            if (sample_hit) begin
                sample_q[pkt_ch_q*RSP_W +: RSP_W] <= rsp_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < P_NO_CH; i++) thresh_q[i] <= THRESH_RST;
        end else if (cfg_wr_i) begin
            case (cfg_sel)
                CFG_SEL_MIN:  thresh_q[cfg_ch].min <= cfg_wdata_i;
                CFG_SEL_MAX:  thresh_q[cfg_ch].max <= cfg_wdata_i;
                CFG_SEL_CTRL: begin
                    thresh_q[cfg_ch].en  <= cfg_wdata_i[0];
                    thresh_q[cfg_ch].sgn <= cfg_wdata_i[1];
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < P_NO_CH; g++) begin : g_ch
        assign ctrl_wr[g] = cfg_wr_i && (cfg_sel == CFG_SEL_CTRL) && (cfg_ch == P_CH_W'(g));
        assign eval[g]    = sample_hit && (pkt_ch_q == P_CH_W'(g));

        sensor_rsp_ch_eval #(
            .P_DEBOUNCE (P_DEBOUNCE)
        ) u_eval (
            .clk       (clk),
            .reset     (reset),
            .thresh_i  (thresh_q[g]),
            .sample_i  (rsp_data_i),
            .eval_i    (eval[g]),
            .ctrl_wr_i (ctrl_wr[g]),
            .ch_ok_o   (ch_ok[g])
        );
    end

    // p2: aggregation towards the safety logic
    always_ff @(posedge clk) begin
        if (reset) begin
            all_good_q <= 1'b1;
            fault_q    <= 1'b0;
        end else begin
            all_good_q <= &ch_ok;
`ifdef SENSOR_RSP_STICKY_EN
            if (!(&ch_ok))        fault_q <= 1'b1;
            else if (fault_clr_i) fault_q <= 1'b0;
`else
            fault_q <= ~(&ch_ok);
`endif
        end
    end

`ifndef SENSOR_RSP_STICKY_EN
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr_i;
`endif

    assign sample_o      = sample_q;
    assign ch_ok_o       = ch_ok;
    assign all_good_o    = all_good_q;
    assign fault_o       = fault_q;
    assign sample_done_o = sample_done_q;
    assign proto_err_o   = proto_err_q;

endmodule
